// File: rtl/mem_access.sv
// LC3 memory-access stage: issues data-memory requests for loads, stores and
// LDI/STI pointer indirection, returns load data and a one-cycle completion pulse.
// Latency: request registered 1 cycle after IDLE samples mem_state; completion
// pulse 1 cycle after dmem_ack.
// Backpressure: the request is held stable until dmem_ack; the controller waits
// for complete_data.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mem_state                 0=read, 1=indirect pointer read, 2=write, 3=idle
//   M_Addr, M_Data            effective address / store data from execute
//   DMem_dout, dmem_ack       memory read data and request acknowledge
//   dmem_req, dmem_we         request valid, 1=write
//   DMem_addr, DMem_din       request address, write data
//   memout                    last load result to writeback
//   complete_data             one-cycle pulse at the end of each access
//   mem_err                   sticky timeout flag
//
// Optional build macro MEM_TIMEOUT_EN: abort an access after TIMEOUT cycles
// without dmem_ack, flagging mem_err. Without it the stage waits indefinitely.
module mem_access #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mem_state,
    input  logic [ADDR_W-1:0] M_Addr,
    input  logic [DATA_W-1:0] M_Data,
    input  logic [DATA_W-1:0] DMem_dout,
    input  logic              dmem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] DMem_addr,
    output logic [DATA_W-1:0] DMem_din,
    output logic [DATA_W-1:0] memout,
    output logic              complete_data,
    output logic              mem_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IND,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              ptr_valid;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    assign mem_err = err_q;
`else
    // No watchdog in this build: the flag can never be raised.
    assign mem_err = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            DMem_addr     <= '0;
            DMem_din      <= '0;
            memout        <= '0;
            complete_data <= 1'b0;
            ptr           <= '0;
            ptr_valid     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt      <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            complete_data <= 1'b0;
            case (state)
                S_IDLE: begin
`ifdef MEM_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    case (mem_state)
                        2'd0: begin
                            state     <= S_RD;
                            dmem_req  <= 1'b1;
                            dmem_we   <= 1'b0;
                            // Second half of LDI targets the fetched pointer.
                            DMem_addr <= ptr_valid ? ptr : M_Addr;
                            ptr_valid <= 1'b0;
                        end
                        2'd1: begin
                            state     <= S_IND;
                            dmem_req  <= 1'b1;
                            dmem_we   <= 1'b0;
                            DMem_addr <= M_Addr;
                            // A stale pointer must not survive a new indirection,
                            // in case this one never completes.
                            ptr_valid <= 1'b0;
                        end
                        2'd2: begin
                            state     <= S_WR;
                            dmem_req  <= 1'b1;
                            dmem_we   <= 1'b1;
                            DMem_addr <= ptr_valid ? ptr : M_Addr;
                            DMem_din  <= M_Data;
                            ptr_valid <= 1'b0;
                        end
                        default: begin
                            ptr_valid <= 1'b0;
                        end
                    endcase
                end

                S_IND, S_RD, S_WR: begin
                    // An ack on the same edge as the timeout wins.
                    if (dmem_ack) begin
                        dmem_req      <= 1'b0;
                        complete_data <= 1'b1;
                        state         <= S_DONE;
                        if (state == S_IND) begin
                            ptr       <= DMem_dout[ADDR_W-1:0];
                            ptr_valid <= 1'b1;
                        end else if (state == S_RD) begin
                            memout <= DMem_dout;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        dmem_req      <= 1'b0;
                        complete_data <= 1'b1;
                        state         <= S_DONE;
                        err_q         <= 1'b1;
                        if (state == S_RD) begin
                            memout <= '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                // mem_state is not sampled here so the controller has a cycle
                // to advance it after seeing complete_data.
                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mem_state;
    logic [15:0] M_Addr;
    logic [15:0] M_Data;
    logic [15:0] DMem_dout;
    logic        dmem_ack;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] DMem_addr;
    logic [15:0] DMem_din;
    logic [15:0] memout;
    logic        complete_data;
    logic        mem_err;

    int tests = 0;
    int fails = 0;

    mem_access #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(15)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_state     (mem_state),
        .M_Addr        (M_Addr),
        .M_Data        (M_Data),
        .DMem_dout     (DMem_dout),
        .dmem_ack      (dmem_ack),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .DMem_addr     (DMem_addr),
        .DMem_din      (DMem_din),
        .memout        (memout),
        .complete_data (complete_data),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ms;
        logic [15:0] addr;
        logic [15:0] data;
        int          delay;      // extra request cycles with ack low
        logic [15:0] dout;
        logic [15:0] exp_addr;
        logic        exp_we;
        logic [15:0] exp_din;
        logic [15:0] exp_memout;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge with the
    // DUT back in IDLE and mem_state parked at 3.
    task automatic access(input vec_t v);
        mem_state = v.ms;
        M_Addr    = v.addr;
        M_Data    = v.data;
        @(negedge clk);
        // Mid-access changes must be ignored.
        mem_state = 2'(v.ms + 2'd1);
        M_Addr    = ~v.addr;
        M_Data    = ~v.data;
        chk("req_rise", 32'(dmem_req), 32'd1);
        chk("req_addr", 32'(DMem_addr), 32'(v.exp_addr));
        chk("req_we", 32'(dmem_we), 32'(v.exp_we));
        if (v.exp_we) chk("req_din", 32'(DMem_din), 32'(v.exp_din));
        chk("no_early_complete", 32'(complete_data), 32'd0);
        for (int i = 0; i < v.delay; i++) begin
            @(negedge clk);
            chk("req_hold", {15'd0, dmem_req, DMem_addr}, {15'd0, 1'b1, v.exp_addr});
        end
        dmem_ack  = 1'b1;
        DMem_dout = v.dout;
        @(negedge clk);
        dmem_ack  = 1'b0;
        DMem_dout = 16'hDEAD;
        chk("req_drop", 32'(dmem_req), 32'd0);
        chk("complete_pulse", 32'(complete_data), 32'd1);
        chk("memout", 32'(memout), 32'(v.exp_memout));
        @(negedge clk);
        mem_state = 2'd3;
        chk("complete_single", 32'(complete_data), 32'd0);
        chk("idle_no_req", 32'(dmem_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        //          ms    addr      data      dly dout      exp_addr  we    din       memout
        vecs[0] = '{2'd0, 16'h3010, 16'h0000, 2, 16'hBEEF, 16'h3010, 1'b0, 16'h0000, 16'hBEEF}; // plain read
        vecs[1] = '{2'd2, 16'h4000, 16'h1234, 0, 16'h0000, 16'h4000, 1'b1, 16'h1234, 16'hBEEF}; // plain write
        vecs[2] = '{2'd1, 16'h3000, 16'h0000, 1, 16'h5005, 16'h3000, 1'b0, 16'h0000, 16'hBEEF}; // LDI pointer
        vecs[3] = '{2'd0, 16'h1111, 16'h0000, 3, 16'h00AA, 16'h5005, 1'b0, 16'h0000, 16'h00AA}; // LDI read
        vecs[4] = '{2'd1, 16'h3002, 16'h0000, 0, 16'h6000, 16'h3002, 1'b0, 16'h0000, 16'h00AA}; // STI pointer
        vecs[5] = '{2'd2, 16'h2222, 16'h7777, 1, 16'h0000, 16'h6000, 1'b1, 16'h7777, 16'h00AA}; // STI write
        vecs[6] = '{2'd0, 16'h0123, 16'h0000, 0, 16'h4321, 16'h0123, 1'b0, 16'h0000, 16'h4321}; // ptr consumed
        vecs[7] = '{2'd0, 16'hFFFF, 16'h0000, 5, 16'hA5A5, 16'hFFFF, 1'b0, 16'h0000, 16'hA5A5}; // full width
        vecs[8] = '{2'd2, 16'hFFFF, 16'hFFFF, 0, 16'h0000, 16'hFFFF, 1'b1, 16'hFFFF, 16'hA5A5}; // full width

        rst       = 1'b1;
        mem_state = 2'd3;
        M_Addr    = 16'h0;
        M_Data    = 16'h0;
        DMem_dout = 16'h0;
        dmem_ack  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {14'd0, dmem_req, dmem_we, complete_data, mem_err},
            {14'd0, 4'b0000});
        chk("rst_addr_din", {DMem_addr, DMem_din}, 32'd0);
        chk("rst_memout", 32'(memout), 32'd0);
        rst = 1'b0;

        // Stray ack while idle is ignored.
        dmem_ack = 1'b1;
        repeat (2) @(negedge clk);
        dmem_ack = 1'b0;
        chk("idle_ack_req", 32'(dmem_req), 32'd0);
        chk("idle_ack_complete", 32'(complete_data), 32'd0);

        for (int i = 0; i < 9; i++) access(vecs[i]);
        chk("no_err_normal", 32'(mem_err), 32'd0);

        // Reset mid-read after an indirection: request drops, no pulse,
        // pointer forgotten.
        access('{2'd1, 16'h3004, 16'h0, 0, 16'h5555, 16'h3004, 1'b0, 16'h0, 16'hA5A5});
        mem_state = 2'd0;
        @(negedge clk);
        mem_state = 2'd3;
        chk("rst_mid_req_up", {16'd0, DMem_addr}, {16'd0, 16'h5555});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_req", 32'(dmem_req), 32'd0);
        chk("rst_mid_complete", 32'(complete_data), 32'd0);
        chk("rst_mid_vals", {DMem_addr, memout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_no_pulse", 32'(complete_data), 32'd0);
        access('{2'd0, 16'h0ABC, 16'h0, 0, 16'h0F0F, 16'h0ABC, 1'b0, 16'h0, 16'h0F0F});

`ifdef MEM_TIMEOUT_EN
        // Read with ack never arriving.
        mem_state = 2'd0;
        M_Addr    = 16'h7000;
        @(negedge clk);
        mem_state = 2'd3;
        n = 0;
        while (dmem_req === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("to_req_cycles", 32'(n), 32'd15);
        chk("to_complete", 32'(complete_data), 32'd1);
        chk("to_err", 32'(mem_err), 32'd1);
        chk("to_memout", 32'(memout), 32'd0);
        @(negedge clk);
        chk("to_err_sticky", 32'(mem_err), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("to_err_clr", 32'(mem_err), 32'd0);
        // Ack on the 15th request cycle completes normally.
        access('{2'd0, 16'h7002, 16'h0, 14, 16'h1357, 16'h7002, 1'b0, 16'h0, 16'h1357});
        chk("to_ack_wins", 32'(mem_err), 32'd0);
`else
        // Long wait without the watchdog still completes normally.
        access('{2'd0, 16'h7002, 16'h0, 30, 16'h1357, 16'h7002, 1'b0, 16'h0, 16'h1357});
        chk("no_to_err", 32'(mem_err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
